instr_fetch_unit: RTL

Instruction fetch front end for the single-cycle processor datapath. Owns the fetch program counter and issues word-aligned read addresses to the synchronous-read instruction memory. Collects the returned words in a small prefetch queue and hands each instruction, tagged with its PC, to decode over a valid/ready handshake. It also accepts branch/jump redirects, which flush all queued and in-flight instructions.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 85 ++++++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction fetch front end.
package fetch_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int PC_STEP = 4;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO; the head entry is held in registers so decode sees no
// combinational path from pop or flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output entry_t           head_entry
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             head_valid_reg, head_valid_next;
  entry_t           head_entry_reg, head_entry_next;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && head_valid_reg;

  always_comb begin
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    head_valid_next = head_valid_reg;
    head_entry_next = head_entry_reg;
    if (flush) begin
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      count_next      = '0;
      head_valid_next = 1'b0;
      head_entry_next = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop_ok) rd_ptr_next = ptr_inc(rd_ptr_reg);
      count_next      = count_reg + CNT_W'(push) - CNT_W'(pop_ok);
      head_valid_next = (count_next != '0);
      // The pushed word becomes the head when it is the only entry left.
      if (push && (count_reg == '0 || (pop_ok && count_reg == CNT_W'(1))))
        head_entry_next = push_entry;
      else if (pop_ok && count_reg > CNT_W'(1))
        head_entry_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_entry_reg <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      head_entry_reg <= head_entry_next;
    end
  end

  assign count      = count_reg;
  assign head_valid = head_valid_reg;
  assign head_entry = head_entry_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, credit-based request issue to a synchronous-read IMEM, and
// redirect handling in front of the prefetch queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] fpc_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic              inflight_reg;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    pending;
  logic              credit_ok;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_aligned;
  entry_t            push_entry;
  entry_t            head_entry;

  // A pop this cycle is not credited, so a push can never land on a full queue.
  assign pending   = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign credit_ok = pending < (CNT_W + 1)'(DEPTH);
  assign imem_req  = !reset && !redirect_valid && credit_ok;
  assign imem_addr = fpc_reg;
  assign fetch_pc  = fpc_reg;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_reg      <= RESET_PC;
      req_addr_reg <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) req_addr_reg <= fpc_reg;
      if (redirect_valid) fpc_reg <= redirect_aligned;
      else if (imem_req) fpc_reg <= fpc_reg + ADDR_W'(PC_STEP);
    end
  end

  assign push            = inflight_reg && !redirect_valid;
  assign pop             = instr_valid && instr_ready;
  assign push_entry.pc   = req_addr_reg;
  assign push_entry.data = imem_rdata;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (q_count),
    .head_valid (instr_valid),
    .head_entry (head_entry)
  );

  assign instr_pc   = head_entry.pc;
  assign instr_data = head_entry.data;

endmodule
